// File: rtl/front_end_pkg.sv
// Shared front-end types and instruction field constants for the IF/ID control slice.
package front_end_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int RS1_LO = 15;
  localparam int RS2_LO = 20;
  localparam int REG_W  = 5;

  localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_shadow.sv
// Shadow copy of the IF/ID instruction and PC: flush clears, hold keeps, otherwise loads.
module if_id_shadow
  import front_end_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         hold,
  input  logic [N-1:0] d_instr,
  input  logic [N-1:0] d_pc,
  output logic [N-1:0] q_instr,
  output logic [N-1:0] q_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_instr <= N'(ZERO_INSTR);
      q_pc    <= '0;
    end else if (flush) begin
      q_instr <= N'(ZERO_INSTR);
      q_pc    <= '0;
    end else if (!hold) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard control: load-use stall FSM, external stall and branch flush.
// All control outputs are combinational; the shadow mirrors IF/ID on each edge.
module if_id_hazard_ctrl
  import front_end_pkg::*;
#(
  parameter int N            = 32,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] if_instr,
  input  logic [N-1:0] if_pc,
  input  logic         idex_mem_read,
  input  logic [4:0]   idex_rd,
  input  logic         branch_taken,
  input  logic         ext_stall,
  output logic         ifid_flush,
  output logic         ifid_hold,
  output logic [N-1:0] hold_instr,
  output logic [N-1:0] hold_pc,
  output logic         pc_write,
  output logic         idex_bubble,
  output logic         stalled
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [N-1:0]       shadow_instr, shadow_pc;
  logic [REG_W-1:0]   rs1, rs2;
  logic               luse;
  logic               flush_c, hold_c, pc_write_c, bubble_c;

  if_id_shadow #(.N(N)) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (ifid_flush),
    .hold    (ifid_hold),
    .d_instr (if_instr),
    .d_pc    (if_pc),
    .q_instr (shadow_instr),
    .q_pc    (shadow_pc)
  );

  assign rs1  = shadow_instr[RS1_LO +: REG_W];
  assign rs2  = shadow_instr[RS2_LO +: REG_W];
  assign luse = idex_mem_read && (idex_rd != '0) && ((idex_rd == rs1) || (idex_rd == rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    flush_c    = 1'b0;
    hold_c     = 1'b0;
    pc_write_c = 1'b1;
    bubble_c   = 1'b0;
    if (branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      state_n  = RUN;
      cnt_n    = '0;
    end else if (ext_stall) begin
      // State and counter freeze so a stall countdown resumes afterwards.
      hold_c     = 1'b1;
      pc_write_c = 1'b0;
      bubble_c   = 1'b1;
    end else if (state == STALL) begin
      hold_c     = 1'b1;
      pc_write_c = 1'b0;
      bubble_c   = 1'b1;
      cnt_n      = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state_n = RUN;
    end else if (luse) begin
      hold_c     = 1'b1;
      pc_write_c = 1'b0;
      bubble_c   = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_n = STALL;
        cnt_n   = CNT_W'(STALL_CYCLES - 1);
      end
    end
  end

  // IF/ID has no reset; flushing during reset is what clears it.
  assign ifid_flush  = rst_n ? flush_c    : 1'b1;
  assign ifid_hold   = rst_n ? hold_c     : 1'b0;
  assign pc_write    = rst_n ? pc_write_c : 1'b0;
  assign idex_bubble = rst_n ? bubble_c   : 1'b1;
  assign stalled     = rst_n && (state == STALL);
  assign hold_instr  = rst_n ? shadow_instr : '0;
  assign hold_pc     = rst_n ? shadow_pc    : '0;

endmodule
